exe_stage_mdu: RTL and testbench
================================

// Module: exe_stage_mdu
// PURPOSE
//  Parametrised, multi-cycle multiply/divide execute unit (RV M-extension) beside the single-cycle ALU/branch path.
//  - Accepts one op per valid/ready handshake and iterates radix-2: shift-add for multiply, restoring for divide.
//  - Holds the result until the writeback side accepts it.
//  - Supports XLEN-wide ops and word (*W) ops via is_word_opt.
// PARAMETERS
//  XLEN   64  operand/result width (32 or 64)
//  TAG_W  5   width of rd tag carried through unchanged
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  flush        in   1       kill in-flight op (branch/jump redirect)
//  in_valid     in   1       request valid
//  in_ready     out  1       unit can accept (IDLE and !flush)
//  md_op        in   3       0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  is_word_opt  in   1       *W op: use op[31:0], sign-extend 32-bit result
//  op1          in   XLEN    rs1 value / dividend
//  op2          in   XLEN    rs2 value / divisor
//  rd_tag_i     in   TAG_W   destination tag, captured on accept
//  out_valid    out  1       result valid
//  out_ready    in   1       consumer accepts result
//  rd_data      out  XLEN    result
//  rd_tag_o     out  TAG_W   captured tag
// BEHAVIOUR
//  - Reset values: in_ready=0 during the rst cycle, then 1.
//    out_valid=0, rd_data=0, rd_tag_o=0. FSM enters IDLE.
//  - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: in_ready=1 unless flush.
//    - On in_valid&&in_ready, latch op1, op2, md_op, is_word_opt and rd_tag_i.
//    - Take absolute values for signed ops. Load iteration counter N: 32 if is_word_opt or XLEN==32, else XLEN.
//    - Go to BUSY.
//  - BUSY: one iteration per cycle; counter decrements. When counter reaches 0, apply sign fix-up and go to DONE.
//  - Latency: op accepted at edge t; out_valid first high after edge t+N+1 (N+1 cycles), e.g. 65 for 64-bit MUL.
//  - DONE: out_valid=1, rd_data/rd_tag_o stable.
//    - On out_valid&&out_ready, go to IDLE.
//    - The next op may be accepted no earlier than the cycle after the hand-off; no overlap.
//  - Width rules:
//    - MUL returns the low XLEN bits of the 2*XLEN product.
//    - MULH/MULHSU/MULHU return the high XLEN bits (signed x signed, signed x unsigned, unsigned x unsigned).
//    - Word ops (valid only for MUL/DIV/DIVU/REM/REMU) compute on bits [31:0] and sign-extend result bit 31 to XLEN.
//    - is_word_opt with MULH* is undefined; result is don't-care but the FSM must still complete normally.
//  - Divide by zero:
//    - quotient = all ones (DIV/DIVU).
//    - remainder = dividend (sign-extended for word ops).
//  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
//  - flush:
//    - In any state, next state is IDLE, out_valid=0 next cycle, result discarded.
//    - flush with in_valid in IDLE: not accepted (in_ready=0 that cycle).
//  - rst mid-operation: same as flush, plus outputs return to reset values.
//  - out_ready while not DONE: ignored.
// CONFIGURATION
//  - Macro MDU_EARLY_OUT_EN.
//  - Defined: shortcut path goes IDLE -> DONE directly (out_valid one cycle after accept) when any of these hold:
//    - divisor==0,
//    - signed overflow,
//    - either multiply operand==0.
//  - Not defined: every op takes the full N+1 cycles, with identical results.
// TESTING
//  1. XLEN=64: MUL 7*-3 -> rd_data=0xFFFF_FFFF_FFFF_FFEB after exactly 65 cycles; tag echoed.
//  2. DIV op1=-7, op2=2 -> 0xFFFF_FFFF_FFFF_FFFD; REM same operands -> 0xFFFF_FFFF_FFFF_FFFF.
//  3. DIVU by 0 -> all ones; REMW op1=0x1_8000_0000, op2=0 -> 0xFFFF_FFFF_8000_0000.
//     - With MDU_EARLY_OUT_EN, out_valid must be high the cycle after accept.
//  4. DIV 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000; REM -> 0.
//  5. out_ready held low 10 cycles in DONE -> out_valid, rd_data and rd_tag_o stable; in_ready=0 throughout.
//  6. flush at BUSY cycle 20 -> out_valid never rises; a new MULHU(all ones, 2) accepted afterwards returns 1.

Source files
------------

// File: rtl/exe_stage_mdu.sv
// exe_stage_mdu: multi-cycle radix-2 multiply/divide unit for RV M-extension ops (shift-add / restoring).
// Optional macro MDU_EARLY_OUT_EN: shortcut IDLE->DONE for zero mul operand, divide-by-zero and signed overflow.
module exe_stage_mdu #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       md_op,
    input  logic             is_word_opt,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rd_data,
    output logic [TAG_W-1:0] rd_tag_o
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return {{(XLEN - 31){x[31]}}, x[30:0]};
    endfunction

    logic            a_sgn, b_sgn, is_div, sa, sb, div0_in;
    logic [XLEN-1:0] a_val, b_val, a_mag, b_mag;

    always_comb begin
        is_div  = md_op[2];
        a_sgn   = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
        b_sgn   = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
        a_val   = op1;
        b_val   = op2;
        if (is_word_opt) begin
            a_val = a_sgn ? sext32(op1) : XLEN'(op1[31:0]);
            b_val = b_sgn ? sext32(op2) : XLEN'(op2[31:0]);
        end
        sa      = a_sgn & a_val[XLEN-1];
        sb      = b_sgn & b_val[XLEN-1];
        a_mag   = sa ? -a_val : a_val;
        b_mag   = sb ? -b_val : b_val;
        div0_in = is_div && (b_val == '0);
    end

`ifdef MDU_EARLY_OUT_EN
    logic            early, ovf_in;
    logic [XLEN-1:0] min_val, early_res;

    always_comb begin
        min_val = {1'b1, {(XLEN - 1){1'b0}}};
        if (is_word_opt) min_val = sext32(XLEN'(32'h8000_0000));
        ovf_in    = is_div && b_sgn && (a_val == min_val) && (b_val == '1);
        early     = div0_in || ovf_in || (!is_div && ((a_val == '0) || (b_val == '0)));
        early_res = '0;
        if (div0_in)
            early_res = md_op[1] ? (is_word_opt ? sext32(op1) : op1) : '1;
        else if (ovf_in)
            early_res = md_op[1] ? '0 : a_val;
    end
`endif

    logic [2:0]        op_r;
    logic              word_r, neg_res, neg_rem, div0_r;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, mcand, prod_s;
    logic [XLEN-1:0]   mplier, rem, quo, divisor, res, fix_res;
    logic [XLEN:0]     r_shift, diff;

    assign r_shift  = {rem, quo[XLEN-1]};
    assign diff     = r_shift - {1'b0, divisor};
    assign in_ready = (state == IDLE) && !flush && !rst;

    // Magnitude result is corrected here; divide-by-zero quotient overrides the sign rule.
    always_comb begin
        prod_s = neg_res ? -acc : acc;
        case (op_r)
            3'd0:             res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       res = div0_r ? '1 : (neg_res ? -quo : quo);
            default:          res = neg_rem ? -rem : rem;
        endcase
        fix_res = word_r ? sext32(res) : res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rd_data   <= '0;
            rd_tag_o  <= '0;
            cnt       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r     <= md_op;
                    word_r   <= is_word_opt;
                    rd_tag_o <= rd_tag_i;
                    neg_res  <= sa ^ sb;
                    neg_rem  <= sa;
                    div0_r   <= div0_in;
                    cnt      <= is_word_opt ? CW'(32) : CW'(XLEN);
                    acc      <= '0;
                    mcand    <= {{XLEN{1'b0}}, a_mag};
                    mplier   <= b_mag;
                    rem      <= '0;
                    // Word dividends are left-aligned so 32 steps consume exactly their bits.
                    quo      <= is_word_opt ? (a_mag << (XLEN - 32)) : a_mag;
                    divisor  <= b_mag;
`ifdef MDU_EARLY_OUT_EN
                    if (early) begin
                        rd_data <= early_res;
                        state   <= DONE;
                    end else begin
                        state   <= BUSY;
                    end
`else
                    state    <= BUSY;
`endif
                end
                BUSY: if (cnt != '0) begin
                    cnt    <= cnt - CW'(1);
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= r_shift[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    rd_data   <= fix_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_stage_mdu.sv
// tb_exe_stage_mdu: directed and randomized checks of exe_stage_mdu (XLEN=64) against an arithmetic reference.
module tb_exe_stage_mdu;
    logic        clk;
    logic        rst, flush, in_valid, in_ready, is_word_opt, out_valid, out_ready;
    logic [2:0]  md_op;
    logic [63:0] op1, op2, rd_data;
    logic [4:0]  rd_tag_i, rd_tag_o;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    exe_stage_mdu #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .md_op(md_op), .is_word_opt(is_word_opt), .op1(op1), .op2(op2), .rd_tag_i(rd_tag_i),
        .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data), .rd_tag_o(rd_tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] x, y;
        logic signed [31:0] x32, y32;
        logic [31:0]        r32;
        logic [63:0]        r;
        r = '0;
        if (w) begin
            x32 = a[31:0];
            y32 = b[31:0];
            r32 = '0;
            case (op)
                3'd4: if (y32 == 0) r32 = '1;
                      else if (a[31:0] == 32'h8000_0000 && y32 == -1) r32 = a[31:0];
                      else r32 = x32 / y32;
                3'd5: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
                3'd6: if (y32 == 0) r32 = a[31:0];
                      else if (a[31:0] == 32'h8000_0000 && y32 == -1) r32 = '0;
                      else r32 = x32 % y32;
                3'd7: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
                default: r32 = a[31:0] * b[31:0];
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            x = a;
            y = b;
            case (op)
                3'd0: r = a * b;
                3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
                3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
                3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
                3'd4: if (b == 0) r = '1; else if (a == MIN64 && b == '1) r = a; else r = x / y;
                3'd5: if (b == 0) r = '1; else r = a / b;
                3'd6: if (b == 0) r = a; else if (a == MIN64 && b == '1) r = '0; else r = x % y;
                default: if (b == 0) r = a; else r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        int n;
        n = w ? 33 : 65;
`ifdef MDU_EARLY_OUT_EN
        if (op[2]) begin
            if (w ? (b[31:0] == 0) : (b == 0)) n = 1;
            if ((op == 3'd4 || op == 3'd6) &&
                (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == '1)))
                n = 1;
        end else if (w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0)) begin
            n = 1;
        end
`endif
        return n;
    endfunction

    task automatic run_op(input string nm, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp, input logic chk_data, input int hold,
                          input logic rdy_busy);
        int cyc;
        int lat;
        lat = exp_lat(op, w, a, b);
        check_eq({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        md_op = op; is_word_opt = w; op1 = a; op2 = b; rd_tag_i = tag;
        in_valid = 1'b1; out_ready = rdy_busy;
        @(posedge clk); #1;
        in_valid = 1'b0; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; rd_tag_i = ~tag;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check_eq({nm, "_latency"}, 64'(cyc), 64'(lat));
        if (chk_data) check_eq({nm, "_data"}, rd_data, exp);
        check_eq({nm, "_tag"}, 64'(rd_tag_o), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
            check_eq({nm, "_hold_data"}, rd_data, exp);
            check_eq({nm, "_hold_tag"}, 64'(rd_tag_o), 64'(tag));
            check_eq({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({nm, "_handoff"}, 64'(out_valid), 64'd0);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return MIN64;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int seen;
        logic [2:0]  r_op;
        logic        r_w;
        logic [63:0] r_a, r_b;
        logic [4:0]  r_tag;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; md_op = '0; is_word_opt = 1'b0;
        op1 = '0; op2 = '0; rd_tag_i = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_rd_data", rd_data, 64'd0);
        check_eq("rst_tag", 64'(rd_tag_o), 64'd0);
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul_7xm3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'h13,
               64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 0, 1'b0);
        run_op("div_m7_2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h01,
               64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 0, 1'b1);
        run_op("rem_m7_2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h02,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0);
        run_op("divu_by0", 3'd5, 1'b0, 64'h1234_5678, 64'd0, 5'h03, '1, 1'b1, 0, 1'b0);
        run_op("remw_by0", 3'd6, 1'b1, 64'h1_8000_0000, 64'd0, 5'h04,
               64'hFFFF_FFFF_8000_0000, 1'b1, 0, 1'b1);
        run_op("div_ovf", 3'd4, 1'b0, MIN64, '1, 5'h05, MIN64, 1'b1, 0, 1'b0);
        run_op("rem_ovf", 3'd6, 1'b0, MIN64, '1, 5'h06, 64'd0, 1'b1, 0, 1'b0);
        run_op("mul_hold", 3'd0, 1'b0, 64'd123, 64'd456, 5'h1A, 64'd56088, 1'b1, 10, 1'b0);
        run_op("mulw_wrap", 3'd0, 1'b1, 64'hFFFF_0000_0001_0000, 64'h0001_0000, 5'h07,
               64'd0, 1'b1, 0, 1'b0);
        run_op("mulh_word", 3'd1, 1'b1, 64'd5, 64'd6, 5'h08, 64'd0, 1'b0, 0, 1'b0);

        // flush during BUSY
        md_op = 3'd0; is_word_opt = 1'b0; op1 = 64'd3; op2 = 64'd5; rd_tag_i = 5'h09;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("flush_busy_no_valid", 64'(seen), 64'd0);
        run_op("mulhu_after_flush", 3'd3, 1'b0, '1, 64'd2, 5'h0A, 64'd1, 1'b1, 0, 1'b0);

        // flush with in_valid in IDLE must not accept
        md_op = 3'd0; op1 = 64'd9; op2 = 64'd9; in_valid = 1'b1; flush = 1'b1; #1;
        check_eq("flush_idle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("flush_idle_no_accept", 64'(seen), 64'd0);

        // flush in DONE drops the result
        md_op = 3'd5; op1 = 64'd100; op2 = 64'd7; rd_tag_i = 5'h0B; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 200) begin
            @(posedge clk); #1;
            seen++;
        end
        check_eq("flush_done_reached", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; #1;
        check_eq("flush_done_valid", 64'(out_valid), 64'd0);
        check_eq("flush_done_in_ready", 64'(in_ready), 64'd1);

        for (int n = 0; n < 60; n++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_w   = (r_op == 3'd0 || r_op[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_a   = pick_operand();
            r_b   = pick_operand();
            r_tag = 5'($urandom);
            run_op($sformatf("rnd%0d_op%0d_w%0d", n, r_op, r_w), r_op, r_w, r_a, r_b, r_tag,
                   ref_res(r_op, r_w, r_a, r_b), 1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // reset mid-operation after a nonzero result is on rd_data
        run_op("pre_rst_mul", 3'd0, 1'b0, 64'd11, 64'd13, 5'h1F, 64'd143, 1'b1, 0, 1'b0);
        md_op = 3'd4; op1 = 64'd1000; op2 = 64'd3; rd_tag_i = 5'h0C; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1; #1;
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_rd_data", rd_data, 64'd0);
        check_eq("mid_rst_tag", 64'(rd_tag_o), 64'd0);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("mid_rst_no_valid", 64'(seen), 64'd0);
        run_op("after_rst_divu", 3'd5, 1'b0, 64'd1000, 64'd3, 5'h0D, 64'd333, 1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
